// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the instruction encoder: class codes, ALU-control codes, opcodes, funct fields.
// The ALU-control values match the encoding used by alu_deco.
package instr_enc_pkg;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LW  = 3'd2,
    CLS_SW  = 3'd3,
    CLS_BEQ = 3'd4,
    CLS_JAL = 3'd5
  } instr_class_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LS  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  function automatic logic aluLegal(input logic [2:0] alu);
    case (alu)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: aluLegal = 1'b1;
      default:                                    aluLegal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] funct3Of(input logic [2:0] alu);
    case (alu)
      ALU_ADD, ALU_SUB: funct3Of = F3_ADD;
      ALU_AND:          funct3Of = F3_AND;
      ALU_OR:           funct3Of = F3_OR;
      ALU_SLT:          funct3Of = F3_SLT;
      default:          funct3Of = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle between the load sequencer (master) and the encoder (slave).
interface instr_enc_if #(parameter int AW = 32);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_class;
  logic [2:0]    in_alu;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [31:0]   in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;

  modport master (
    output in_valid, in_class, in_alu, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_class, in_alu, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_encoder_imm_pack.sv
// Places the immediate bits of an I/S/B/J-format instruction; all other bit positions are 0.
module instr_imm_pack
  import instr_enc_pkg::*;
(
  input  instr_class_e cls,
  input  logic [20:0]  immLo,
  output logic [31:0]  immBits
);

  always_comb begin
    immBits = '0;
    case (cls)
      CLS_I, CLS_LW: immBits[31:20] = immLo[11:0];
      CLS_SW: begin
        immBits[31:25] = immLo[11:5];
        immBits[11:7]  = immLo[4:0];
      end
      CLS_BEQ: begin
        immBits[31]    = immLo[12];
        immBits[30:25] = immLo[10:5];
        immBits[11:8]  = immLo[4:1];
        immBits[7]     = immLo[11];
      end
      CLS_JAL: immBits[31:12] = {immLo[20], immLo[10:1], immLo[11], immLo[19:12]};
      default: immBits = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I-subset instruction encoder with a 2-entry output FIFO and wrapping byte-address counter.
// Optional macro INSTR_ENC_RANGE_CHECK_EN rejects immediates that do not fit their format.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  instr_enc_if.slave  bus,
  output logic        err,
  output logic [7:0]  err_cnt
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(4 * (DEPTH - 1));

  instr_class_e        cls;
  logic [2:0]          alu;
  logic signed [31:0]  imm;
  logic [31:0]         immBits;
  logic [31:0]         encWord;
  logic                legal;
  logic                immOk;
  logic [6:0]          opcode, f7;
  logic [2:0]          f3;
  logic [4:0]          rdF, rs1F, rs2F;

  logic [1:0]          count;
  logic [AW-1:0]       addrCnt, nextAddr;
  logic [31:0]         headInstr_p1, tailInstr_p1;
  logic [AW-1:0]       headAddr_p1, tailAddr_p1;
  logic                accept, push, pop, bad;

  assign cls = instr_class_e'(bus.in_class);
  assign alu = bus.in_alu;
  assign imm = $signed(bus.in_imm);

  instr_imm_pack uImmPack (
    .cls     (cls),
    .immLo   (bus.in_imm[20:0]),
    .immBits (immBits)
  );

`ifdef INSTR_ENC_RANGE_CHECK_EN
  always_comb begin
    immOk = 1'b1;
    case (cls)
      CLS_I, CLS_LW, CLS_SW: immOk = (imm >= -32'sd2048) && (imm <= 32'sd2047);
      CLS_BEQ: immOk = (imm >= -32'sd4096) && (imm <= 32'sd4094) && !imm[0];
      CLS_JAL: immOk = (imm >= -32'sd1048576) && (imm <= 32'sd1048574) && !imm[0];
      default: immOk = 1'b1;
    endcase
  end
`else
  logic unusedImmHi;
  assign unusedImmHi = ^imm[31:21];
  assign immOk = 1'b1;
`endif

  // Field selection per class; fields a class does not use stay 0
  always_comb begin
    opcode = '0;
    f3     = '0;
    f7     = F7_ZERO;
    rdF    = '0;
    rs1F   = '0;
    rs2F   = '0;
    legal  = 1'b1;
    case (cls)
      CLS_R: begin
        opcode = OP_R;
        f3     = funct3Of(alu);
        f7     = (alu == ALU_SUB) ? F7_SUB : F7_ZERO;
        rdF    = bus.in_rd;
        rs1F   = bus.in_rs1;
        rs2F   = bus.in_rs2;
        legal  = aluLegal(alu);
      end
      CLS_I: begin
        opcode = OP_I;
        f3     = funct3Of(alu);
        rdF    = bus.in_rd;
        rs1F   = bus.in_rs1;
        legal  = aluLegal(alu) && (alu != ALU_SUB);
      end
      CLS_LW: begin
        opcode = OP_LOAD;
        f3     = F3_LS;
        rdF    = bus.in_rd;
        rs1F   = bus.in_rs1;
      end
      CLS_SW: begin
        opcode = OP_STORE;
        f3     = F3_LS;
        rs1F   = bus.in_rs1;
        rs2F   = bus.in_rs2;
      end
      CLS_BEQ: begin
        opcode = OP_BRANCH;
        f3     = F3_BEQ;
        rs1F   = bus.in_rs1;
        rs2F   = bus.in_rs2;
      end
      CLS_JAL: begin
        opcode = OP_JAL;
        rdF    = bus.in_rd;
      end
      default: legal = 1'b0;
    endcase
  end

  assign encWord  = {f7, rs2F, rs1F, f3, rdF, opcode} | immBits;
  assign nextAddr = (addrCnt == LAST_ADDR) ? '0 : addrCnt + AW'(4);

  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_instr = headInstr_p1;
  assign bus.out_addr  = headAddr_p1;

  // Illegal requests complete the handshake but never enter the FIFO
  assign accept = bus.in_valid && bus.in_ready && !flush;
  assign push   = accept && legal && immOk;
  assign bad    = accept && !(legal && immOk);
  assign pop    = bus.out_valid && bus.out_ready && !flush;

  // ---- stage p1: FIFO head, address counter, error state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= '0;
      addrCnt      <= '0;
      headInstr_p1 <= '0;
      headAddr_p1  <= '0;
      err          <= 1'b0;
      err_cnt      <= '0;
    end else begin
      if (flush) begin
        count   <= '0;
        addrCnt <= '0;
      end else begin
        if (push) addrCnt <= nextAddr;
        case ({push, pop})
          2'b10: begin
            count <= count + 2'd1;
            if (count == 2'd0) begin
              headInstr_p1 <= encWord;
              headAddr_p1  <= addrCnt;
            end
          end
          2'b01: begin
            count        <= count - 2'd1;
            headInstr_p1 <= tailInstr_p1;
            headAddr_p1  <= tailAddr_p1;
          end
          2'b11: begin
            headInstr_p1 <= encWord;
            headAddr_p1  <= addrCnt;
          end
          default: ;
        endcase
      end
      if (bad) begin
        err <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  // Second slot only fills when a push lands behind an entry that is not leaving
  always_ff @(posedge clk) begin
    if (push && !pop && count == 2'd1) begin
      tailInstr_p1 <= encWord;
      tailAddr_p1  <= addrCnt;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed table-driven bench for instr_encoder (DEPTH=4 so address wrap is reachable quickly).
module tb_instr_encoder;
  import instr_enc_pkg::*;

`ifdef INSTR_ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       err;
  logic [7:0] err_cnt;

  instr_enc_if #(.AW(32)) bus ();

  instr_encoder #(.DEPTH(4), .AW(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .bus     (bus),
    .err     (err),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  cls;
    logic [2:0]  alu;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    bit          baseLegal;
    bit          rangeBad;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs[17];
  int   nChecks = 0;
  int   nPass   = 0;
  int   expErr  = 0;
  logic [31:0] expAddr = '0;

  function automatic vec_t mk(string nm, logic [2:0] c, logic [2:0] a, logic [4:0] d,
                              logic [4:0] s1, logic [4:0] s2, logic [31:0] im,
                              bit lg, bit rb, logic [31:0] ins);
    vec_t v;
    v.name = nm; v.cls = c; v.alu = a; v.rd = d; v.rs1 = s1; v.rs2 = s2;
    v.imm = im; v.baseLegal = lg; v.rangeBad = rb; v.instr = ins;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input logic [2:0] c, input logic [2:0] a, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
    bus.in_class = c; bus.in_alu = a; bus.in_rd = d;
    bus.in_rs1 = s1; bus.in_rs2 = s2; bus.in_imm = im;
  endtask

  initial begin
    bit legal;

    vecs[0]  = mk("add_x3_x1_x2",  3'd0, 3'b000, 5'd3, 5'd1, 5'd2, 32'd0,        1, 0, 32'h002081B3);
    vecs[1]  = mk("sub_x5_x6_x7",  3'd0, 3'b001, 5'd5, 5'd6, 5'd7, 32'd0,        1, 0, 32'h407302B3);
    vecs[2]  = mk("lw_x4_8_x2",    3'd2, 3'b000, 5'd4, 5'd2, 5'd0, 32'd8,        1, 0, 32'h00812203);
    vecs[3]  = mk("beq_m4",        3'd4, 3'b000, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1, 0, 32'hFE208EE3);
    vecs[4]  = mk("ialu_sub",      3'd1, 3'b001, 5'd1, 5'd1, 5'd0, 32'd1,        0, 0, 32'h0);
    vecs[5]  = mk("addi_x1_m1",    3'd1, 3'b000, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1, 0, 32'hFFF00093);
    vecs[6]  = mk("sw_x5_12_x2",   3'd3, 3'b000, 5'd0, 5'd2, 5'd5, 32'd12,       1, 0, 32'h00512623);
    vecs[7]  = mk("and_x1_x2_x3",  3'd0, 3'b010, 5'd1, 5'd2, 5'd3, 32'd0,        1, 0, 32'h003170B3);
    vecs[8]  = mk("or_x4_x4_x5",   3'd0, 3'b011, 5'd4, 5'd4, 5'd5, 32'd0,        1, 0, 32'h00526233);
    vecs[9]  = mk("slt_x6_x7_x8",  3'd0, 3'b101, 5'd6, 5'd7, 5'd8, 32'd0,        1, 0, 32'h0083A333);
    vecs[10] = mk("jal_x1_p8",     3'd5, 3'b000, 5'd1, 5'd3, 5'd4, 32'd8,        1, 0, 32'h008000EF);
    vecs[11] = mk("class6",        3'd6, 3'b000, 5'd1, 5'd1, 5'd1, 32'd0,        0, 0, 32'h0);
    vecs[12] = mk("r_alu100",      3'd0, 3'b100, 5'd1, 5'd1, 5'd1, 32'd0,        0, 0, 32'h0);
    vecs[13] = mk("beq_m3",        3'd4, 3'b000, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFD, 1, 1, 32'hFE208EE3);
    vecs[14] = mk("addi_4096",     3'd1, 3'b000, 5'd2, 5'd0, 5'd0, 32'd4096,     1, 1, 32'h00000113);
    vecs[15] = mk("jal_x0_m2",     3'd5, 3'b000, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFE, 1, 0, 32'hFFFFF06F);
    vecs[16] = mk("lw_alu_ignored",3'd2, 3'b001, 5'd1, 5'd0, 5'd0, 32'd0,        1, 0, 32'h00002083);

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    setReq(3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst/out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst/out_instr", bus.out_instr, 32'd0);
    chk("rst/out_addr",  bus.out_addr,  32'd0);
    chk("rst/err",       {31'd0, err},  32'd0);
    chk("rst/err_cnt",   {24'd0, err_cnt}, 32'd0);
    chk("rst/in_ready",  {31'd0, bus.in_ready}, 32'd1);

    for (int i = 0; i < 17; i++) begin
      setReq(vecs[i].cls, vecs[i].alu, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      bus.in_valid = 1'b1;
      chk({vecs[i].name, "/in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      step();
      bus.in_valid = 1'b0;
      legal = vecs[i].baseLegal && !(RC && vecs[i].rangeBad);
      chk({vecs[i].name, "/out_valid"}, {31'd0, bus.out_valid}, {31'd0, legal});
      if (legal) begin
        chk({vecs[i].name, "/instr"}, bus.out_instr, vecs[i].instr);
        chk({vecs[i].name, "/addr"},  bus.out_addr,  expAddr);
        expAddr = (expAddr + 32'd4) % 32'd16;
      end else begin
        expErr = (expErr == 255) ? 255 : expErr + 1;
      end
      chk({vecs[i].name, "/err_cnt"}, {24'd0, err_cnt}, expErr);
      chk({vecs[i].name, "/err"}, {31'd0, err}, (expErr != 0) ? 32'd1 : 32'd0);
      step();
    end

    // Backpressure: third request stalls until the consumer drains
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("bp/flush_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b0;
    setReq(3'd0, 3'd0, 5'd1, 5'd1, 5'd2, 32'd0);
    bus.in_valid = 1'b1;
    step();
    chk("bp/ready_after1", {31'd0, bus.in_ready}, 32'd1);
    chk("bp/head1", bus.out_instr, 32'h002080B3);
    setReq(3'd0, 3'd0, 5'd2, 5'd1, 5'd2, 32'd0);
    step();
    chk("bp/ready_after2", {31'd0, bus.in_ready}, 32'd0);
    chk("bp/head_hold", bus.out_instr, 32'h002080B3);
    chk("bp/addr_hold", bus.out_addr, 32'd0);
    setReq(3'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    step();
    chk("bp/ready_full", {31'd0, bus.in_ready}, 32'd0);
    chk("bp/head_stable", bus.out_instr, 32'h002080B3);
    chk("bp/valid_full", {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    step();
    chk("bp/second_instr", bus.out_instr, 32'h00208133);
    chk("bp/second_addr", bus.out_addr, 32'd4);
    chk("bp/ready_again", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp/third_instr", bus.out_instr, 32'h002081B3);
    chk("bp/third_addr", bus.out_addr, 32'd8);
    step();
    chk("bp/drained", {31'd0, bus.out_valid}, 32'd0);

    // Address wrap with DEPTH=4
    flush = 1'b1;
    step();
    flush = 1'b0;
    setReq(3'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      chk($sformatf("wrap/addr%0d", k), bus.out_addr, (k * 4) % 16);
      step();
    end

    // Flush with two entries buffered and a request pending
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    repeat (2) step();
    chk("fl/valid_before", {31'd0, bus.out_valid}, 32'd1);
    chk("fl/ready_before", {31'd0, bus.in_ready}, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl/valid_after", {31'd0, bus.out_valid}, 32'd0);
    chk("fl/ready_after", {31'd0, bus.in_ready}, 32'd1);
    chk("fl/err_cnt_kept", {24'd0, err_cnt}, expErr);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("fl/next_addr", bus.out_addr, 32'd0);
    chk("fl/next_valid", {31'd0, bus.out_valid}, 32'd1);
    step();

    // err_cnt saturates at 255
    setReq(3'd7, 3'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    bus.in_valid = 1'b1;
    repeat (260) step();
    bus.in_valid = 1'b0;
    chk("sat/err_cnt", {24'd0, err_cnt}, 32'd255);
    chk("sat/err", {31'd0, err}, 32'd1);
    chk("sat/no_output", {31'd0, bus.out_valid}, 32'd0);

    // Asynchronous reset while a word is waiting
    bus.out_ready = 1'b0;
    setReq(3'd0, 3'd1, 5'd5, 5'd6, 5'd7, 32'd0);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("ar/valid_before", {31'd0, bus.out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar/valid", {31'd0, bus.out_valid}, 32'd0);
    chk("ar/instr", bus.out_instr, 32'd0);
    chk("ar/addr", bus.out_addr, 32'd0);
    chk("ar/err", {31'd0, err}, 32'd0);
    chk("ar/err_cnt", {24'd0, err_cnt}, 32'd0);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("ar/post_instr", bus.out_instr, 32'h407302B3);
    chk("ar/post_addr", bus.out_addr, 32'd0);
    step();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
